// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - state, opcode and ALU select constants for the multicycle control FSM
// Also provides the per-state control word decode shared by the top module.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_R_LAST = 4'h7;
  localparam logic [3:0] OP_ADDI   = 4'h8;
  localparam logic [3:0] OP_ANDI   = 4'h9;
  localparam logic [3:0] OP_ORI    = 4'hA;
  localparam logic [3:0] OP_LW     = 4'hB;
  localparam logic [3:0] OP_SW     = 4'hC;
  localparam logic [3:0] OP_BEQ    = 4'hD;
  localparam logic [3:0] OP_JMP    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [1:0] ALU_A_PC   = 2'b00;
  localparam logic [1:0] ALU_A_REG  = 2'b01;
  localparam logic [1:0] ALU_A_ZERO = 2'b10;

  localparam logic [2:0] ALU_B_REG  = 3'b000;
  localparam logic [2:0] ALU_B_ONE  = 3'b001;
  localparam logic [2:0] ALU_B_SEXT = 3'b010;
  localparam logic [2:0] ALU_B_ZEXT = 3'b011;
  localparam logic [2:0] ALU_B_JUMP = 3'b100;

  typedef struct packed {
    logic       pc_sel;
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       im_read;
    logic       dm_read;
    logic       dm_wr;
    logic       data_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_wr;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
  } ctrl_t;

  // Every field defaults to 0; each state raises only what its datapath step needs.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.im_read   = 1'b1;
        c.pc_wr     = 1'b1;
        c.alu_src_a = ALU_A_PC;
        c.alu_src_b = ALU_B_ONE;
      end
      S_DECODE: begin
        c.alu_src_a = ALU_A_PC;
        c.alu_src_b = ALU_B_SEXT;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = ALU_A_REG;
        c.alu_src_b = ALU_B_SEXT;
      end
      S_MEM_RD: c.dm_read = 1'b1;
      S_MEM_WB: begin
        c.reg_wr     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.dm_wr    = 1'b1;
        c.data_src = 1'b1;
      end
      S_R_EXE: begin
        c.alu_src_a = ALU_A_REG;
        c.alu_src_b = ALU_B_REG;
      end
      S_R_WB: begin
        c.reg_wr  = 1'b1;
        c.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = ALU_A_REG;
        c.alu_src_b  = ALU_B_REG;
        c.pc_wr_cond = 1'b1;
        c.pc_sel     = 1'b1;
      end
      S_JUMP: begin
        c.alu_src_a = ALU_A_ZERO;
        c.alu_src_b = ALU_B_JUMP;
        c.pc_wr     = 1'b1;
      end
      S_I_EXE: begin
        c.alu_src_a = ALU_A_REG;
        c.alu_src_b = (op == OP_ADDI) ? ALU_B_SEXT : ALU_B_ZEXT;
      end
      S_I_WB: c.reg_wr = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_next_state.sv
// rtl/control_next_state.sv - combinational next-state and illegal-opcode logic
// CONTROL_HALT_EN: when defined, opcode 0xF enters HALT and stays there until reset.
module control_next_state
  import control_pkg::*;
(
  input  state_t     p_state,
  input  logic [3:0] opcode,
  output state_t     n_state,
  output logic       opcode_flag
);

  always_comb begin
    n_state     = S_FETCH;
    opcode_flag = 1'b0;
    case (p_state)
      S_FETCH: n_state = S_DECODE;
      S_DECODE: begin
        if (opcode <= OP_R_LAST)                         n_state = S_R_EXE;
        else if (opcode <= OP_ORI)                       n_state = S_I_EXE;
        else if (opcode == OP_LW || opcode == OP_SW)     n_state = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                       n_state = S_BRANCH;
        else if (opcode == OP_JMP)                       n_state = S_JUMP;
        else begin
`ifdef CONTROL_HALT_EN
          n_state = S_HALT;
`else
          n_state     = S_FETCH;
          opcode_flag = 1'b1;
`endif
        end
      end
      S_MEM_ADDR: n_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   n_state = S_MEM_WB;
      S_R_EXE:    n_state = S_R_WB;
      S_I_EXE:    n_state = S_I_WB;
`ifdef CONTROL_HALT_EN
      S_HALT:     n_state = S_HALT;
`endif
      default:    n_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore main control FSM for the multicycle 16-bit RISC core
// CONTROL_HALT_EN selects HALT behaviour for opcode 0xF (see control_next_state).
module multicycle_control
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       PC_Sel,
  output logic       PC_Wr,
  output logic       PC_Wr_Cond,
  output logic       IM_Read,
  output logic       DM_Read,
  output logic       DM_Wr,
  output logic       Data_Src,
  output logic       Reg_Dst,
  output logic       Mem_to_Reg,
  output logic       Reg_Wr,
  output logic [1:0] ALU_Src_A,
  output logic [2:0] ALU_Src_B,
  output logic [3:0] p_state,
  output logic [3:0] n_state,
  output logic       opcode_flag
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  control_next_state u_next_state (
    .p_state     (state_q),
    .opcode      (opcode),
    .n_state     (state_d),
    .opcode_flag (opcode_flag)
  );

  // The control word is loaded on the same edge as the state it belongs to, so it is
  // always exactly the decode of p_state; the IR holds opcode stable across that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH, opcode);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d, opcode);
    end
  end

  assign p_state    = state_q;
  assign n_state    = state_d;
  assign PC_Sel     = ctrl_q.pc_sel;
  assign PC_Wr      = ctrl_q.pc_wr;
  assign PC_Wr_Cond = ctrl_q.pc_wr_cond;
  assign IM_Read    = ctrl_q.im_read;
  assign DM_Read    = ctrl_q.dm_read;
  assign DM_Wr      = ctrl_q.dm_wr;
  assign Data_Src   = ctrl_q.data_src;
  assign Reg_Dst    = ctrl_q.reg_dst;
  assign Mem_to_Reg = ctrl_q.mem_to_reg;
  assign Reg_Wr     = ctrl_q.reg_wr;
  assign ALU_Src_A  = ctrl_q.alu_src_a;
  assign ALU_Src_B  = ctrl_q.alu_src_b;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
// Honours CONTROL_HALT_EN the same way as the design.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       PC_Sel, PC_Wr, PC_Wr_Cond, IM_Read, DM_Read, DM_Wr, Data_Src;
  logic       Reg_Dst, Mem_to_Reg, Reg_Wr, opcode_flag;
  logic [1:0] ALU_Src_A;
  logic [2:0] ALU_Src_B;
  logic [3:0] p_state, n_state;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

`ifdef CONTROL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .PC_Sel(PC_Sel), .PC_Wr(PC_Wr), .PC_Wr_Cond(PC_Wr_Cond), .IM_Read(IM_Read),
    .DM_Read(DM_Read), .DM_Wr(DM_Wr), .Data_Src(Data_Src), .Reg_Dst(Reg_Dst),
    .Mem_to_Reg(Mem_to_Reg), .Reg_Wr(Reg_Wr), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B),
    .p_state(p_state), .n_state(n_state), .opcode_flag(opcode_flag)
  );

  logic [14:0] outs;
  assign outs = {PC_Sel, PC_Wr, PC_Wr_Cond, IM_Read, DM_Read, DM_Wr, Data_Src,
                 Reg_Dst, Mem_to_Reg, Reg_Wr, ALU_Src_A, ALU_Src_B};

  // Expected control word per state, bit order matching outs.
  function automatic logic [14:0] exp_out(input int s, input logic [3:0] op);
    logic [14:0] v;
    v = '0;
    case (s)
      0:  begin v[13] = 1'b1; v[11] = 1'b1; v[2:0] = 3'b001; end
      1:  v[2:0] = 3'b010;
      2:  begin v[4:3] = 2'b01; v[2:0] = 3'b010; end
      3:  v[10] = 1'b1;
      4:  begin v[5] = 1'b1; v[6] = 1'b1; end
      5:  begin v[9] = 1'b1; v[8] = 1'b1; end
      6:  v[4:3] = 2'b01;
      7:  begin v[5] = 1'b1; v[7] = 1'b1; end
      8:  begin v[4:3] = 2'b01; v[12] = 1'b1; v[14] = 1'b1; end
      9:  begin v[4:3] = 2'b10; v[2:0] = 3'b100; v[13] = 1'b1; end
      10: begin v[4:3] = 2'b01; v[2:0] = (op == 4'h8) ? 3'b010 : 3'b011; end
      11: v[5] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // State walk of one instruction, derived from its opcode class.
  task automatic push_path(input logic [3:0] op);
    exp_q.push_back(0);
    exp_q.push_back(1);
    if (op <= 4'h7)       begin exp_q.push_back(6); exp_q.push_back(7); end
    else if (op <= 4'hA)  begin exp_q.push_back(10); exp_q.push_back(11); end
    else if (op == 4'hB)  begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
    else if (op == 4'hC)  begin exp_q.push_back(2); exp_q.push_back(5); end
    else if (op == 4'hD)  exp_q.push_back(8);
    else if (op == 4'hE)  exp_q.push_back(9);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    int         n;
    int         st[6];
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   head, nxt;
    logic [3:0] op;

    v.op = 4'h3; v.n = 4; v.st = '{0, 1, 6, 7, 0, 0};    tbl.push_back(v);
    v.op = 4'h0; v.n = 4; v.st = '{0, 1, 6, 7, 0, 0};    tbl.push_back(v);
    v.op = 4'hB; v.n = 5; v.st = '{0, 1, 2, 3, 4, 0};    tbl.push_back(v);
    v.op = 4'hC; v.n = 4; v.st = '{0, 1, 2, 5, 0, 0};    tbl.push_back(v);
    v.op = 4'hD; v.n = 3; v.st = '{0, 1, 8, 0, 0, 0};    tbl.push_back(v);
    v.op = 4'hE; v.n = 3; v.st = '{0, 1, 9, 0, 0, 0};    tbl.push_back(v);
    v.op = 4'h8; v.n = 4; v.st = '{0, 1, 10, 11, 0, 0};  tbl.push_back(v);
    v.op = 4'h9; v.n = 4; v.st = '{0, 1, 10, 11, 0, 0};  tbl.push_back(v);
    v.op = 4'hA; v.n = 4; v.st = '{0, 1, 10, 11, 0, 0};  tbl.push_back(v);
    if (!HALT_EN) begin
      v.op = 4'hF; v.n = 2; v.st = '{0, 1, 0, 0, 0, 0};  tbl.push_back(v);
    end

    // Reset with an arbitrary opcode lands in FETCH with FETCH outputs.
    opcode = 4'hD;
    step();
    rst = 1'b0;
    check("reset_p_state", {28'd0, p_state}, 32'd0);
    check("reset_outs", {17'd0, outs}, {17'd0, 15'h2801});

    foreach (tbl[i]) begin
      do_reset();
      opcode = tbl[i].op;
      #1;
      for (int j = 0; j < tbl[i].n; j++) begin
        check($sformatf("tbl%0d_state%0d", i, j), {28'd0, p_state}, tbl[i].st[j]);
        check($sformatf("tbl%0d_outs%0d", i, j), {17'd0, outs},
              {17'd0, exp_out(tbl[i].st[j], tbl[i].op)});
        check($sformatf("tbl%0d_flag%0d", i, j), {31'd0, opcode_flag},
              {31'd0, (tbl[i].st[j] == 1 && tbl[i].op == 4'hF)});
        step();
      end
      check($sformatf("tbl%0d_return", i), {28'd0, p_state}, 32'd0);
    end

    // Illegal opcode alternates FETCH/DECODE.
    if (!HALT_EN) begin
      do_reset();
      opcode = 4'hF;
      #1;
      for (int k = 0; k < 4; k++) begin
        check("illegal_seq_state", {28'd0, p_state}, k % 2);
        check("illegal_seq_flag", {31'd0, opcode_flag}, k % 2);
        step();
      end
    end

    // Reset in the middle of a load forces FETCH at the next edge.
    do_reset();
    opcode = 4'hB;
    repeat (3) step();
    check("mid_rst_pre", {28'd0, p_state}, 32'd3);
    check("mid_rst_dmread", {31'd0, DM_Read}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", {28'd0, p_state}, 32'd0);
    check("mid_rst_outs", {17'd0, outs}, {17'd0, 15'h2801});

    if (HALT_EN) begin
      do_reset();
      opcode = 4'hF;
      #1;
      check("halt_decode_flag", {31'd0, opcode_flag}, 32'd0);
      step();
      check("halt_decode_flag2", {31'd0, opcode_flag}, 32'd0);
      check("halt_decode_next", {28'd0, n_state}, 32'd12);
      for (int k = 0; k < 5; k++) begin
        step();
        check("halt_state", {28'd0, p_state}, 32'd12);
        check("halt_outs", {17'd0, outs}, 32'd0);
        check("halt_flag", {31'd0, opcode_flag}, 32'd0);
      end
      do_reset();
      check("halt_rst_state", {28'd0, p_state}, 32'd0);
    end

    // Random back-to-back instructions against the path model.
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      if (exp_q.size() == 0) begin
        op = 4'($urandom_range(0, HALT_EN ? 14 : 15));
        opcode = op;
        push_path(op);
        #1;
      end
      head = exp_q.pop_front();
      nxt  = (exp_q.size() != 0) ? exp_q[0] : 0;
      check("rand_state", {28'd0, p_state}, head);
      check("rand_outs", {17'd0, outs}, {17'd0, exp_out(head, opcode)});
      check("rand_next", {28'd0, n_state}, nxt);
      check("rand_flag", {31'd0, opcode_flag}, {31'd0, (head == 1 && opcode == 4'hF)});
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
